// File: rtl/stream_packet_checker_pkg.sv
// -----------------------------------------------------------------------------
// stream_packet_checker_pkg
// Shared definitions for the test-packet stream checker: default framing
// constants, error codes reported on first_err_code, and FSM state encoding.
// -----------------------------------------------------------------------------
package stream_packet_checker_pkg;

  localparam logic [31:0] HEADER_WORD_DEFAULT = 32'h0100_0360;
  localparam int          PAYLOAD_LEN_DEFAULT = 216;
  localparam int          IDX_W               = 9;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_HDR  = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_DATA = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/stream_packet_checker_ready.sv
// -----------------------------------------------------------------------------
// stream_ready_lfsr
// Generates the registered TREADY for the packet checker.
//   READY_MODE = 0 : ready is 1 whenever not in reset
//   READY_MODE = 1 : ready follows lfsr[0] | lfsr[1] (~75% duty), where the
//                    LFSR (x^16+x^14+x^13+x^11+1) steps every cycle.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  asynchronous, active-high
//   ready out 1  registered ready, 0 during reset
// -----------------------------------------------------------------------------
module stream_ready_lfsr
  import stream_packet_checker_pkg::*;
#(
  parameter int          READY_MODE = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  output logic ready
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        ready_q, ready_d;
  logic        feedback;

  always_comb begin
    // Right-shifting Fibonacci form: taps 16,14,13,11 map to bits 0,2,3,5.
    feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d   = {feedback, lfsr_q[15:1]};
    ready_d  = (READY_MODE == 1) ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= LFSR_SEED;
      ready_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/stream_packet_checker.sv
// -----------------------------------------------------------------------------
// stream_packet_checker
// AXI-Stream slave that terminates the channel-tester packet stream, checks
// header / payload sequence / TLAST framing and keeps packet statistics.
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   output_r_TDATA_0     in  32  stream data
//   output_r_TVALID_0    in  1   stream valid
//   output_r_TLAST_0     in  1   last beat of packet
//   output_r_TREADY_0    out 1   registered ready (never depends on TVALID)
//   clear_stats          in  1   sync pulse: zero counters and sticky flags
//   pkt_ok_count         out 32  good packets, saturating
//   err_count            out 16  bad packets, saturating
//   err_flag             out 1   sticky error flag
//   first_err_code       out 2   code of first error since reset/clear
//   busy                 out 1   inside a packet
// -----------------------------------------------------------------------------
module stream_packet_checker
  import stream_packet_checker_pkg::*;
#(
  parameter logic [31:0] HEADER_WORD = HEADER_WORD_DEFAULT,
  parameter int          PAYLOAD_LEN = PAYLOAD_LEN_DEFAULT,
  parameter int          READY_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] output_r_TDATA_0,
  input  logic        output_r_TVALID_0,
  input  logic        output_r_TLAST_0,
  output logic        output_r_TREADY_0,
  input  logic        clear_stats,
  output logic [31:0] pkt_ok_count,
  output logic [15:0] err_count,
  output logic        err_flag,
  output logic [1:0]  first_err_code,
  output logic        busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN);

  logic             ready;
  logic             accept;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bad_q, bad_d;
  logic [31:0]      ok_cnt_q, ok_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;
  err_code_e        first_err_q, first_err_d;
  logic             err_event;
  err_code_e        err_code;
  logic             end_ok, end_err;

  stream_ready_lfsr #(
    .READY_MODE (READY_MODE),
    .LFSR_SEED  (LFSR_SEED)
  ) u_ready (
    .clk   (clk),
    .reset (reset),
    .ready (ready)
  );

  assign accept = output_r_TVALID_0 & ready;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bad_d       = bad_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    first_err_d = first_err_q;
    err_event   = 1'b0;
    err_code    = ERR_NONE;
    end_ok      = 1'b0;
    end_err     = 1'b0;

    if (accept) begin
      unique case (state_q)
        ST_HEADER: begin
          if (output_r_TDATA_0 != HEADER_WORD) begin
            err_event = 1'b1;
            err_code  = ERR_HDR;
          end else if (output_r_TLAST_0) begin
            err_event = 1'b1;
            err_code  = ERR_LEN;
          end
          if (!err_event) begin
            state_d = ST_PAYLOAD;
            idx_d   = IDX_W'(1);
            bad_d   = 1'b0;
          end else if (output_r_TLAST_0) begin
            end_err = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end

        ST_PAYLOAD: begin
          if (output_r_TDATA_0 != 32'(idx_q)) begin
            err_event = 1'b1;
            err_code  = ERR_DATA;
            bad_d     = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            if (output_r_TLAST_0) begin
              state_d = ST_HEADER;
              end_ok  = !bad_d;
              end_err = bad_d;
            end else begin
              // Payload complete but no TLAST: a data error on this same beat
              // keeps priority as the reported code.
              if (!err_event) err_code = ERR_LEN;
              err_event = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (output_r_TLAST_0) begin
            if (!err_event) err_code = ERR_LEN;
            err_event = 1'b1;
            state_d   = ST_HEADER;
            end_err   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end

        ST_DRAIN: begin
          if (output_r_TLAST_0) begin
            state_d = ST_HEADER;
            end_err = 1'b1;
          end
        end

        default: state_d = ST_HEADER;
      endcase
    end

    if (end_ok && (ok_cnt_q != '1))   ok_cnt_d  = ok_cnt_q + 32'd1;
    if (end_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    if (err_event && !err_flag_q) begin
      err_flag_d  = 1'b1;
      first_err_d = err_code;
    end

    // Clear overrides any event on the same cycle; the FSM is left alone.
    if (clear_stats) begin
      ok_cnt_d    = '0;
      err_cnt_d   = '0;
      err_flag_d  = 1'b0;
      first_err_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HEADER;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      first_err_q <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bad_q       <= bad_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
      first_err_q <= first_err_d;
    end
  end

  assign output_r_TREADY_0 = ready;
  assign pkt_ok_count      = ok_cnt_q;
  assign err_count         = err_cnt_q;
  assign err_flag          = err_flag_q;
  assign first_err_code    = first_err_q;
  assign busy              = (state_q != ST_HEADER);

endmodule

// File: tb/tb_stream_packet_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_packet_checker
// Two checker instances (always-ready and LFSR backpressure) share one
// stimulus source selected by sel. The driver pushes the expected statistics
// for every packet end into a queue; the monitor pops an entry whenever a TLAST
// beat is accepted and compares the counters one cycle later.
// -----------------------------------------------------------------------------
module tb_stream_packet_checker;

  localparam logic [31:0] HDR = 32'h0100_0360;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] tdata;
  logic        tvalid, tlast, clear_stats;
  int          sel;

  logic        valid0, valid1;
  logic        tready0, tready1;
  logic [31:0] ok0, ok1;
  logic [15:0] err0, err1;
  logic        flag0, flag1;
  logic [1:0]  code0, code1;
  logic        busy0, busy1;

  assign valid0 = tvalid && (sel == 0);
  assign valid1 = tvalid && (sel == 1);

  stream_packet_checker #(.READY_MODE(0)) dut0 (
    .clk               (clk),
    .reset             (reset),
    .output_r_TDATA_0  (tdata),
    .output_r_TVALID_0 (valid0),
    .output_r_TLAST_0  (tlast),
    .output_r_TREADY_0 (tready0),
    .clear_stats       (clear_stats),
    .pkt_ok_count      (ok0),
    .err_count         (err0),
    .err_flag          (flag0),
    .first_err_code    (code0),
    .busy              (busy0)
  );

  stream_packet_checker #(.READY_MODE(1)) dut1 (
    .clk               (clk),
    .reset             (reset),
    .output_r_TDATA_0  (tdata),
    .output_r_TVALID_0 (valid1),
    .output_r_TLAST_0  (tlast),
    .output_r_TREADY_0 (tready1),
    .clear_stats       (clear_stats),
    .pkt_ok_count      (ok1),
    .err_count         (err1),
    .err_flag          (flag1),
    .first_err_code    (code1),
    .busy              (busy1)
  );

  logic        tready, flag, busy;
  logic [31:0] ok_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  code;
  assign tready  = (sel == 1) ? tready1 : tready0;
  assign ok_cnt  = (sel == 1) ? ok1     : ok0;
  assign err_cnt = (sel == 1) ? err1    : err0;
  assign flag    = (sel == 1) ? flag1   : flag0;
  assign code    = (sel == 1) ? code1   : code0;
  assign busy    = (sel == 1) ? busy1   : busy0;

  typedef struct {
    int unsigned ok;
    int unsigned err;
    int unsigned flag;
    int unsigned code;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   stalls = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned ok, input int unsigned err,
                      input int unsigned fl, input int unsigned cd);
    exp_t e;
    e.ok = ok; e.err = err; e.flag = fl; e.code = cd;
    exp_q.push_back(e);
  endtask

  // Called and returns at a falling edge; holds the beat until accepted.
  task automatic send_beat(input logic [31:0] d, input bit last, input bit clr);
    bit seen;
    int n;
    tdata = d; tlast = last; tvalid = 1'b1; clear_stats = clr;
    n = 0;
    forever begin
      #1 seen = tready;
      @(negedge clk);
      if (seen) break;
      stalls++;
      n++;
      if (n > 1000) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    tvalid = 1'b0; tlast = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic send_range(input bit with_hdr, input logic [31:0] hdr,
                            input int k_from, input int k_to,
                            input int bad_k, input logic [31:0] bad_val,
                            input bit last, input bit clr_last);
    if (with_hdr) send_beat(hdr, last && (k_from > k_to), 1'b0);
    for (int k = k_from; k <= k_to; k++)
      send_beat((k == bad_k) ? bad_val : 32'(k), last && (k == k_to),
                clr_last && last && (k == k_to));
  endtask

  task automatic good_pkt();
    send_range(1'b1, HDR, 1, 216, 0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic check_zero_stats(input string tag);
    check({tag, "_ok"},   ok_cnt, 0);
    check({tag, "_err"},  err_cnt, 0);
    check({tag, "_flag"}, flag, 0);
    check({tag, "_code"}, code, 0);
  endtask

  // Called at a falling edge with tvalid low.
  task automatic apply_reset();
    #3 reset = 1'b1;
    #1;
    check("reset_tready", tready, 0);
    check("reset_busy", busy, 0);
    check_zero_stats("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("tready_low_at_release", tready, 0);
    @(negedge clk);
    if (sel == 0) check("tready_rises_after_reset", tready, 1);
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    #1 check_zero_stats("clear");
    @(negedge clk);
  endtask

  // Monitor: note an accepted TLAST beat, then compare stats after that edge.
  initial begin
    bit   hs;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 hs = tvalid && tready && tlast && !reset;
      @(posedge clk);
      #1;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pkt_ok_count", ok_cnt, e.ok);
          check("err_count", err_cnt, e.err);
          check("err_flag", flag, e.flag);
          check("first_err_code", code, e.code);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; clear_stats = 1'b0;
    sel = 0;
    @(negedge clk);
    apply_reset();

    // Three good packets back-to-back.
    push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 0, 0, 0);
    repeat (3) good_pkt();

    // Wrong header, full-length body with TLAST, then a good packet.
    push(3, 1, 1, 1);
    send_range(1'b1, 32'h0100_0361, 1, 216, 0, 32'd0, 1'b1, 1'b0);
    push(4, 1, 1, 1);
    good_pkt();
    pulse_clear();

    // Payload beat 100 carries 99; TLAST at 216 still closes the packet.
    push(0, 1, 1, 3);
    send_range(1'b1, HDR, 1, 216, 100, 32'd99, 1'b1, 1'b0);
    push(1, 1, 1, 3);
    good_pkt();
    pulse_clear();

    // Early TLAST at beat 200, then a packet whose TLAST arrives at beat 220.
    push(0, 1, 1, 2);
    send_range(1'b1, HDR, 1, 200, 0, 32'd0, 1'b1, 1'b0);
    push(0, 2, 1, 2);
    send_range(1'b1, HDR, 1, 220, 0, 32'd0, 1'b1, 1'b0);
    push(1, 2, 1, 2);
    good_pkt();
    pulse_clear();

    // clear_stats coincident with packet end: clear wins, FSM keeps going.
    push(0, 0, 0, 0);
    send_range(1'b1, HDR, 1, 216, 0, 32'd0, 1'b1, 1'b1);
    check("busy_after_cleared_end", busy, 0);
    push(1, 0, 0, 0);
    good_pkt();

    // Reset in the middle of a packet.
    send_range(1'b1, HDR, 1, 49, 0, 32'd0, 1'b0, 1'b0);
    check("busy_mid_packet", busy, 1);
    apply_reset();
    push(0, 1, 1, 1);
    send_range(1'b0, HDR, 50, 216, 0, 32'd0, 1'b1, 1'b0);
    push(1, 1, 1, 1);
    good_pkt();

    // LFSR backpressure instance: ten good packets.
    sel = 1;
    apply_reset();
    stalls = 0;
    for (int p = 1; p <= 10; p++) begin
      push(p, 0, 0, 0);
      good_pkt();
    end
    check("backpressure_seen", (stalls > 0) ? 1 : 0, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
